// File: rtl/cla_pkg.sv
// Shared constants for the carry-lookahead group sequencer: group width,
// FSM encoding and the index-width helper.
package cla_pkg;

  localparam int GROUP_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Bits needed to count 0..n-1, never less than one so a single-group adder still has a counter.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << r) < n) begin
        r = r + 1;
      end
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_group_sequencer_if.sv
// Operand/result handshake bundle for cla_group_sequencer.
interface cla_group_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/cla_group4.sv
// Four-bit lookahead group: carries are flattened two-level functions of the
// group carry-in, so no carry ripples through the spg_block sum outputs.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               c_in,
  output logic [GROUP_W-1:0] s,
  output logic               c_out,
  output logic               c_msb,
  output logic               grp_g,
  output logic               grp_p
);
  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] c;

  for (genvar i = 0; i < GROUP_W; i++) begin : g_bit
    spg_block u_spg (
      .a (a[i]),
      .b (b[i]),
      .c (c[i]),
      .s (s[i]),
      .p (p[i]),
      .g (g[i])
    );
  end

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);

  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;
  assign c_out = grp_g | (grp_p & c_in);
  assign c_msb = c[3];
endmodule

// File: rtl/spg_block.sv
// Per-bit sum / propagate / generate stage.
module spg_block (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic p,
  output logic g
);
  assign g = a & b;
  assign p = a ^ b;
  assign s = p ^ c;
endmodule

// File: rtl/cla_group_sequencer.sv
// Multi-cycle carry-lookahead adder: one shared 4-bit group evaluated per clock,
// lowest group first, with a registered carry linking consecutive groups.
module cla_group_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cla_group_sequencer_if.slave   bus
);
  localparam int NGRP  = WIDTH / GROUP_W;
  localparam int IDX_W = clog2_min1(NGRP);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NGRP - 1);

  if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_bad_width
    $error("cla_group_sequencer: WIDTH must be a non-zero multiple of GROUP_W");
  end

  state_e             state_q,     state_d;
  logic [IDX_W-1:0]   grp_idx_q,   grp_idx_d;
  logic               carry_q,     carry_d;
  logic [WIDTH-1:0]   a_q,         a_d;
  logic [WIDTH-1:0]   b_q,         b_d;
  logic [WIDTH-1:0]   sum_q,       sum_d;
  logic               c_out_q,     c_out_d;
  logic               ovf_q,       ovf_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [GROUP_W-1:0] grp_s;
  logic               grp_c_out;
  logic               grp_c_msb;
  logic               grp_g_unused;
  logic               grp_p_unused;

  cla_group4 u_group (
    .a     (a_q[grp_idx_q*GROUP_W +: GROUP_W]),
    .b     (b_q[grp_idx_q*GROUP_W +: GROUP_W]),
    .c_in  (carry_q),
    .s     (grp_s),
    .c_out (grp_c_out),
    .c_msb (grp_c_msb),
    .grp_g (grp_g_unused),
    .grp_p (grp_p_unused)
  );

  // Next-state and datapath updates; ovf on the last group uses the carry into the MSB.
  always_comb begin
    state_d     = state_q;
    grp_idx_d   = grp_idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.a;
          b_d        = bus.b;
          carry_d    = bus.c_in;
          grp_idx_d  = '0;
          sum_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[grp_idx_q*GROUP_W +: GROUP_W] = grp_s;
        carry_d = grp_c_out;
        if (grp_idx_q == LAST_IDX) begin
          c_out_d     = grp_c_out;
          ovf_d       = grp_c_out ^ grp_c_msb;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          grp_idx_d   = grp_idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d     = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any add in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grp_idx_q   <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_idx_q   <= grp_idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_group_sequencer.sv
// Directed-vector and random bench for cla_group_sequencer (WIDTH=16).
module tb_cla_group_sequencer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_group_sequencer_if #(.WIDTH(W)) bus ();

  cla_group_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         output logic [15:0] s, output logic co, output logic ov, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(n < 50), 32'd1);
    bus.a = a;
    bus.b = b;
    bus.c_in = cin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    s  = bus.sum;
    co = bus.c_out;
    ov = bus.ovf;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s;
    logic        co, ov;
    int          lat;
    logic [16:0] full;
    logic [15:0] ra, rb;
    logic        rc;
    int          got;

    vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[2]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[3]  = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vt[4]  = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
    vt[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[6]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vt[7]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[8]  = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    vt[9]  = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vt[10] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.c_in      = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready",  32'(bus.in_ready),  32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_sum",       32'(bus.sum),       32'd0);
    check("reset_c_out",     32'(bus.c_out),     32'd0);
    check("reset_ovf",       32'(bus.ovf),       32'd0);

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      run_add(vt[i].a, vt[i].b, vt[i].cin, s, co, ov, lat);
      check("vec_latency",  32'(lat),          32'd4);
      check("vec_sum",      32'(s),            32'(vt[i].sum));
      check("vec_c_out",    32'(co),           32'(vt[i].co));
      check("vec_ovf",      32'(ov),           32'(vt[i].ov));
      check("vec_in_ready", 32'(bus.in_ready), 32'd0);
      release_out();
    end

    // Consumer stall: result frozen while out_ready is low
    run_add(16'h1234, 16'h4321, 1'b1, s, co, ov, lat);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_sum",       32'(bus.sum),       32'h5556);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    end
    release_out();
    @(negedge clk);
    check("after_xfer_out_valid", 32'(bus.out_valid), 32'd0);
    check("after_xfer_sum_hold",  32'(bus.sum),       32'h5556);

    // in_valid held high with changing operands: only IDLE edges accept
    bus.out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      check("seq4_in_ready",  32'(bus.in_ready),  32'(k % 6 == 0));
      check("seq4_out_valid", 32'(bus.out_valid), 32'(k % 6 == 5));
      if (bus.out_valid) begin
        got++;
        check("seq4_sum", 32'(bus.sum), 32'(16'((k - 5) * 16'h0111 + 1 + (k - 5))));
      end
      bus.a        = 16'(k * 16'h0111 + 1);
      bus.b        = 16'(k);
      bus.c_in     = 1'b0;
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("seq4_count", 32'(got), 32'd3);

    // Asynchronous reset during the second RUN cycle
    @(negedge clk);
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    bus.c_in     = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrun_sum", 32'(bus.sum), 32'h0003);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_add(16'h0003, 16'h0004, 1'b0, s, co, ov, lat);
    check("post_rst_sum",     32'(s),   32'h0007);
    check("post_rst_latency", 32'(lat), 32'd4);
    release_out();

    // Random operands with random consumer stalls
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
      run_add(ra, rb, rc, s, co, ov, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("rnd_sum_cout", 32'({bus.c_out, bus.sum}), 32'(full));
      check("rnd_ovf", 32'(bus.ovf), 32'((ra[15] == rb[15]) && (full[15] != ra[15])));
      release_out();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
